// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite register file:
//   - resp_e      : AXI response codes (OKAY / SLVERR used by this slave)
//   - clog2       : constant-friendly ceiling log2
//   - lsb_bits    : byte-offset bits ignored for a given data width
//   - idx_bits    : register index width for a given register count
//   - DEF_*       : default geometry used as module parameter defaults
// -----------------------------------------------------------------------------
package axil_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   localparam int DEF_ADDR_W   = 32;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 16;

   // Bounded loop so the function stays usable in constant expressions.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   function automatic int lsb_bits(input int data_w);
      return clog2(data_w / 8);
   endfunction

   function automatic int idx_bits(input int num_regs);
      return clog2(num_regs);
   endfunction

endpackage

// File: rtl/s_axil_regfile_if.sv
// -----------------------------------------------------------------------------
// s_axil_regfile_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   master modport : drives valids/addresses/data and bready/rready
//   slave  modport : drives readies, bvalid/bresp, rvalid/rdata/rresp
// Parameters: ADDR_W address width, DATA_W data width (strobe is DATA_W/8).
// -----------------------------------------------------------------------------
interface s_axil_regfile_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  awvalid;
   logic                  awready;
   logic [ADDR_W-1:0]     awaddr;
   logic                  wvalid;
   logic                  wready;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_W-1:0]     araddr;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_W-1:0]     rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axil_wr_capture.sv
// -----------------------------------------------------------------------------
// axil_wr_capture
// Holds the write address and write data beats independently (either order,
// or together) and raises a commit strobe once both are present and the B
// channel is free.
// Ports:
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_awvalid/o_awready/i_awaddr  write address handshake
//   i_wvalid/o_wready/i_wdata/i_wstrb  write data handshake
//   i_bvalid                    response still pending; blocks the commit
//   o_addr/o_data/o_strb        held beat contents
//   o_commit                    high in the cycle whose edge commits the write
// -----------------------------------------------------------------------------
module axil_wr_capture #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_awvalid,
   output logic                  o_awready,
   input  logic [ADDR_W-1:0]     i_awaddr,
   input  logic                  i_wvalid,
   output logic                  o_wready,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic [DATA_W/8-1:0]   i_wstrb,
   input  logic                  i_bvalid,
   output logic [ADDR_W-1:0]     o_addr,
   output logic [DATA_W-1:0]     o_data,
   output logic [DATA_W/8-1:0]   o_strb,
   output logic                  o_commit
);
   logic                  r_aw_held;
   logic                  r_w_held;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_data;
   logic [DATA_W/8-1:0]   r_strb;
   logic                  w_commit;

   // Readies come straight from the held flags, so they are registered.
   assign o_awready = !r_aw_held;
   assign o_wready  = !r_w_held;

   // A pending response holds both beats, which keeps the readies low and
   // backpressures the master until the B handshake completes.
   assign w_commit = r_aw_held && r_w_held && !i_bvalid;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_strb    <= '0;
      end else if (w_commit) begin
         // Readies are low while both are held, so no capture can collide.
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
      end else begin
         if (i_awvalid && !r_aw_held) begin
            r_aw_held <= 1'b1;
            r_addr    <= i_awaddr;
         end
         if (i_wvalid && !r_w_held) begin
            r_w_held <= 1'b1;
            r_data   <= i_wdata;
            r_strb   <= i_wstrb;
         end
      end
   end

   assign o_addr   = r_addr;
   assign o_data   = r_data;
   assign o_strb   = r_strb;
   assign o_commit = w_commit;
endmodule

// File: rtl/s_axil_regfile.sv
// -----------------------------------------------------------------------------
// s_axil_regfile
// AXI4-Lite slave register bank with byte-strobe writes and a read channel.
// Registers are exported flat to fabric logic with a per-register write pulse.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   s_axi           AXI4-Lite slave bundle (AW, W, B, AR, R)
//   o_regs          register k at [k*DATA_W +: DATA_W]
//   o_wr_pulse      one-cycle pulse on the register hit by a committed write
// Parameters: ADDR_W, DATA_W (32 or 64), NUM_REGS (power of two, >= 2).
// Accesses at or beyond NUM_REGS*(DATA_W/8) answer SLVERR; low byte-offset
// address bits are ignored.
// -----------------------------------------------------------------------------
module s_axil_regfile
   import axil_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   s_axil_regfile_if.slave              s_axi,
   output logic [NUM_REGS*DATA_W-1:0]   o_regs,
   output logic [NUM_REGS-1:0]          o_wr_pulse
);
   localparam int STRB_W = DATA_W / 8;
   localparam int LSB    = lsb_bits(DATA_W);
   localparam int IDX_W  = idx_bits(NUM_REGS);
   // One extra bit so the byte size of the bank cannot wrap at ADDR_W.
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS * STRB_W);

   logic [ADDR_W-1:0]   w_wr_addr;
   logic [DATA_W-1:0]   w_wr_data;
   logic [STRB_W-1:0]   w_wr_strb;
   logic                w_commit;
   logic                w_wr_ok;
   logic [IDX_W-1:0]    w_wr_idx;
   logic [NUM_REGS-1:0] w_pulse_next;
   logic                w_ar_ok;
   logic [IDX_W-1:0]    w_ar_idx;

   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_wr_pulse;
   logic                r_bvalid;
   resp_e               r_bresp;
   logic                r_rvalid;
   logic [DATA_W-1:0]   r_rdata;
   resp_e               r_rresp;

   axil_wr_capture #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_wr_capture (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_awvalid (s_axi.awvalid),
      .o_awready (s_axi.awready),
      .i_awaddr  (s_axi.awaddr),
      .i_wvalid  (s_axi.wvalid),
      .o_wready  (s_axi.wready),
      .i_wdata   (s_axi.wdata),
      .i_wstrb   (s_axi.wstrb),
      .i_bvalid  (r_bvalid),
      .o_addr    (w_wr_addr),
      .o_data    (w_wr_data),
      .o_strb    (w_wr_strb),
      .o_commit  (w_commit)
   );

   // Range checks use the full address so aliases above the bank are errors.
   assign w_wr_ok  = ({1'b0, w_wr_addr} < LIMIT);
   assign w_wr_idx = w_wr_addr[LSB +: IDX_W];
   assign w_ar_ok  = ({1'b0, s_axi.araddr} < LIMIT);
   assign w_ar_idx = s_axi.araddr[LSB +: IDX_W];

   // Per-register decode of the committed write; also drives the pulse.
   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         assign w_pulse_next[gi] = w_commit && w_wr_ok && (w_wr_idx == IDX_W'(gi));
         assign o_regs[gi*DATA_W +: DATA_W] = r_regs[gi];
      end
   endgenerate

   // Register bank: only strobed byte lanes of the selected register change.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            r_regs[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (w_pulse_next[k]) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (w_wr_strb[b]) begin
                     r_regs[k][b*8 +: 8] <= w_wr_data[b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= w_pulse_next;
      end
   end

   // Write response: commit and B handshake are mutually exclusive because
   // the commit strobe requires bvalid to be low.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else if (w_commit) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_bvalid && s_axi.bready) begin
         r_bvalid <= 1'b0;
      end
   end

   // Read path: a read on the same edge as a commit sees the old contents
   // because r_regs is sampled before its non-blocking update lands.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else if (r_rvalid) begin
         if (s_axi.rready) begin
            r_rvalid <= 1'b0;
         end
      end else if (s_axi.arvalid) begin
         r_rvalid <= 1'b1;
         if (w_ar_ok) begin
            r_rdata <= r_regs[w_ar_idx];
            r_rresp <= RESP_OKAY;
         end else begin
            r_rdata <= '0;
            r_rresp <= RESP_SLVERR;
         end
      end
   end

   assign s_axi.arready = !r_rvalid;
   assign s_axi.bvalid  = r_bvalid;
   assign s_axi.bresp   = r_bresp;
   assign s_axi.rvalid  = r_rvalid;
   assign s_axi.rdata   = r_rdata;
   assign s_axi.rresp   = r_rresp;
   assign o_wr_pulse    = r_wr_pulse;
endmodule

// File: tb/tb_s_axil_regfile.sv
// -----------------------------------------------------------------------------
// tb_s_axil_regfile
// Directed stimulus against s_axil_regfile (32-bit data, 16 registers).
// Expected B and R responses are queued when a transaction is issued; a
// monitor process pops and compares them whenever a handshake is presented.
// -----------------------------------------------------------------------------
module tb_s_axil_regfile;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 16;
   localparam int TIMEOUT  = 50;
   localparam int FLAT_W   = NUM_REGS * DATA_W;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [1:0]        resp;
   } r_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   s_axil_regfile_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
   logic [FLAT_W-1:0]   regs;
   logic [NUM_REGS-1:0] wr_pulse;

   s_axil_regfile #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .s_axi      (bus),
      .o_regs     (regs),
      .o_wr_pulse (wr_pulse)
   );

   int checks = 0;
   int errors = 0;
   logic [1:0]        exp_b_q [$];
   r_exp_t            exp_r_q [$];
   logic [DATA_W-1:0] model [NUM_REGS];
   int                pulse_cnt [NUM_REGS];

   task automatic check(input string name, input logic [FLAT_W-1:0] act,
                        input logic [FLAT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_pulse[k]) pulse_cnt[k]++;
         end
         if (bus.bvalid && bus.bready) begin
            if (exp_b_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_unexpected: got bresp %0d expected no response", bus.bresp);
            end else begin
               logic [1:0] eb;
               eb = exp_b_q.pop_front();
               $display("B  bresp=%0d", bus.bresp);
               check("bresp", FLAT_W'(bus.bresp), FLAT_W'(eb));
            end
         end
         if (bus.rvalid && bus.rready) begin
            if (exp_r_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL r_unexpected: got rdata %0h expected no response", bus.rdata);
            end else begin
               r_exp_t er;
               er = exp_r_q.pop_front();
               $display("R  rdata=%08h rresp=%0d", bus.rdata, bus.rresp);
               check("rdata", FLAT_W'(bus.rdata), FLAT_W'(er.data));
               check("rresp", FLAT_W'(bus.rresp), FLAT_W'(er.resp));
            end
         end
      end
   end

   // Queue the expected response and track register contents.
   task automatic push_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                             input logic [3:0] strb);
      if (addr < 32'd64) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[addr[5:2]][b*8 +: 8] = data[b*8 +: 8];
         end
         exp_b_q.push_back(2'b00);
      end else begin
         exp_b_q.push_back(2'b10);
      end
      $display("W  addr=%08h data=%08h strb=%b", addr, data, strb);
   endtask

   // AW and W presented together; returns once both handshakes have happened.
   task automatic issue_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                              input logic [3:0] strb);
      logic aw_done, w_done, aw_fire, w_fire;
      @(posedge clk); #1;
      push_write(addr, data, strb);
      bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      aw_done = 1'b0; w_done = 1'b0;
      for (int i = 0; i < TIMEOUT && !(aw_done && w_done); i++) begin
         @(negedge clk);
         aw_fire = bus.awvalid && bus.awready;
         w_fire  = bus.wvalid && bus.wready;
         @(posedge clk); #1;
         if (aw_fire) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
         if (w_fire)  begin bus.wvalid  = 1'b0; w_done  = 1'b1; end
      end
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      if (!(aw_done && w_done)) fail_now("write_handshake");
   endtask

   task automatic wait_b();
      logic done;
      done = 1'b0;
      for (int i = 0; i < TIMEOUT && !done; i++) begin
         @(negedge clk);
         if (bus.bvalid && bus.bready) begin
            @(posedge clk); #1;
            done = 1'b1;
         end
      end
      if (!done) fail_now("b_wait");
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp_data,
                          input logic [1:0] exp_resp);
      logic ar_done, r_done, fire;
      r_exp_t e;
      @(posedge clk); #1;
      e.data = exp_data; e.resp = exp_resp;
      exp_r_q.push_back(e);
      bus.araddr = addr; bus.arvalid = 1'b1;
      ar_done = 1'b0; r_done = 1'b0;
      for (int i = 0; i < TIMEOUT && !ar_done; i++) begin
         @(negedge clk);
         fire = bus.arvalid && bus.arready;
         @(posedge clk); #1;
         if (fire) begin bus.arvalid = 1'b0; ar_done = 1'b1; end
      end
      bus.arvalid = 1'b0;
      for (int i = 0; i < TIMEOUT && ar_done && !r_done; i++) begin
         @(negedge clk);
         if (bus.rvalid && bus.rready) begin
            @(posedge clk); #1;
            r_done = 1'b1;
         end
      end
      if (!r_done) fail_now("read_handshake");
   endtask

   task automatic check_reset_state();
      check("rst_awready", FLAT_W'(bus.awready), 1);
      check("rst_wready",  FLAT_W'(bus.wready),  1);
      check("rst_arready", FLAT_W'(bus.arready), 1);
      check("rst_bvalid",  FLAT_W'(bus.bvalid),  0);
      check("rst_rvalid",  FLAT_W'(bus.rvalid),  0);
      check("rst_bresp",   FLAT_W'(bus.bresp),   0);
      check("rst_rresp",   FLAT_W'(bus.rresp),   0);
      check("rst_rdata",   FLAT_W'(bus.rdata),   0);
      check("rst_regs",    regs,                 0);
      check("rst_pulse",   FLAT_W'(wr_pulse),    0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [ADDR_W-1:0] TBL_ADDR [10] = '{32'h00, 32'h04, 32'h08, 32'h14, 32'h04,
                                                   32'h10, 32'h00, 32'h0C, 32'h14, 32'h08};

   initial begin
      logic [FLAT_W-1:0] snap;
      int psum, seen_b;
      logic [ADDR_W-1:0] a;

      bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
      bus.bready = 1; bus.arvalid = 0; bus.araddr = 0; bus.rready = 1;
      for (int k = 0; k < NUM_REGS; k++) begin model[k] = '0; pulse_cnt[k] = 0; end

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_state();

      // AW+W together; commit one edge after the handshake edge.
      issue_write(32'h08, 32'h0000_0005, 4'b1111);
      @(negedge clk);
      check("lat_bvalid_early", FLAT_W'(bus.bvalid), 0);
      @(negedge clk);
      check("lat_bvalid",  FLAT_W'(bus.bvalid), 1);
      check("pulse_reg2",  FLAT_W'(wr_pulse),   FLAT_W'(16'h0004));
      @(posedge clk); #1;
      @(negedge clk);
      check("pulse_gone",  FLAT_W'(wr_pulse),   0);
      check("pulse_once",  FLAT_W'(pulse_cnt[2]), 1);
      check("oregs_reg2",  FLAT_W'(regs[2*DATA_W +: DATA_W]), FLAT_W'(32'h5));
      do_read(32'h08, 32'h0000_0005, 2'b00);

      // W leads AW by a cycle.
      @(posedge clk); #1;
      push_write(32'h0C, 32'hAABB_CCDD, 4'b1111);
      bus.awaddr = 32'h0C; bus.wdata = 32'hAABB_CCDD; bus.wstrb = 4'b1111; bus.wvalid = 1;
      @(negedge clk);
      check("wready_free", FLAT_W'(bus.wready), 1);
      @(posedge clk); #1 bus.wvalid = 0;
      @(negedge clk);
      check("wready_held",  FLAT_W'(bus.wready),  0);
      check("awready_free", FLAT_W'(bus.awready), 1);
      @(posedge clk); #1 bus.awvalid = 1;
      @(posedge clk); #1 bus.awvalid = 0;
      wait_b();
      issue_write(32'h0C, 32'h0000_1100, 4'b0010);
      wait_b();
      do_read(32'h0C, 32'hAABB_11DD, 2'b00);

      // Out-of-range write, then an all-zero strobe write.
      snap = regs;
      psum = 0;
      for (int k = 0; k < NUM_REGS; k++) psum += pulse_cnt[k];
      issue_write(32'h40, 32'hDEAD_BEEF, 4'b1111);
      wait_b();
      @(negedge clk);
      check("oor_regs_kept", regs, snap);
      for (int k = 0; k < NUM_REGS; k++) psum -= pulse_cnt[k];
      check("oor_no_pulse", FLAT_W'(psum), 0);
      issue_write(32'h08, 32'hFFFF_FFFF, 4'b0000);
      wait_b();
      @(negedge clk);
      check("strb0_pulse", FLAT_W'(pulse_cnt[2]), 2);
      check("strb0_data",  FLAT_W'(regs[2*DATA_W +: DATA_W]), FLAT_W'(32'h5));
      do_read(32'h14, 32'h0, 2'b00);
      do_read(32'h50, 32'h0, 2'b10);

      // B backpressure: second write is held, not committed.
      bus.bready = 0;
      issue_write(32'h10, 32'h0000_0011, 4'b1111);
      issue_write(32'h18, 32'h0000_0022, 4'b1111);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_awready", FLAT_W'(bus.awready), 0);
         check("bp_wready",  FLAT_W'(bus.wready),  0);
         check("bp_bvalid",  FLAT_W'(bus.bvalid),  1);
      end
      check("bp_no_commit", FLAT_W'(pulse_cnt[6]), 0);
      @(posedge clk); #1 bus.bready = 1;
      @(negedge clk);
      @(negedge clk);
      check("bp_gap",     FLAT_W'(bus.bvalid), 0);
      @(negedge clk);
      check("bp_second",  FLAT_W'(bus.bvalid), 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_drained", FLAT_W'(bus.bvalid), 0);
      check("bp_commit",  FLAT_W'(pulse_cnt[6]), 1);

      // Back-to-back writes, then read back every register.
      for (int i = 0; i < 10; i++) begin
         issue_write(TBL_ADDR[i], DATA_W'(i + 1), 4'b1111);
         wait_b();
      end
      for (int k = 0; k < NUM_REGS; k++) begin
         a = ADDR_W'(k * 4);
         do_read(a, model[k], 2'b00);
      end
      @(negedge clk);
      for (int k = 0; k < NUM_REGS; k++) begin
         check("oregs_model", FLAT_W'(regs[k*DATA_W +: DATA_W]), FLAT_W'(model[k]));
      end

      // Reset with AW held and R pending.
      @(posedge clk); #1;
      bus.awaddr = 32'h20; bus.awvalid = 1;
      @(posedge clk); #1 bus.awvalid = 0;
      bus.rready = 0; bus.araddr = 32'h08; bus.arvalid = 1;
      @(posedge clk); #1 bus.arvalid = 0;
      @(negedge clk);
      check("pre_rst_rvalid",  FLAT_W'(bus.rvalid),  1);
      check("pre_rst_awready", FLAT_W'(bus.awready), 0);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1;
      @(negedge clk);
      check_reset_state();
      for (int k = 0; k < NUM_REGS; k++) begin model[k] = '0; pulse_cnt[k] = 0; end
      @(posedge clk); #1 rst = 0; bus.rready = 1;
      bus.wdata = 32'h99; bus.wstrb = 4'b1111; bus.wvalid = 1;
      @(negedge clk);
      check("post_rst_wready", FLAT_W'(bus.wready), 1);
      @(posedge clk); #1 bus.wvalid = 0;
      seen_b = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.bvalid) seen_b++;
      end
      check("dropped_no_b",     FLAT_W'(seen_b), 0);
      check("dropped_no_pulse", FLAT_W'(pulse_cnt[8]), 0);
      do_read(32'h20, 32'h0, 2'b00);

      @(negedge clk);
      check("pending_b", FLAT_W'(exp_b_q.size()), 0);
      check("pending_r", FLAT_W'(exp_r_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
